// File: rtl/ram_ahb_pkg.sv
// Shared definitions for the AHB-Lite RAM slave: bus encodings, response codes,
// the data-phase FSM state type and the byte-lane decode helper.
package ram_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2
  } state_e;

  // Byte lanes touched by a transfer of the given size at the given low address bits.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr;
      HSIZE_HALF: mask = addr[1] ? 4'b1100 : 4'b0011;
      default:    mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ram_byte_bank.sv
// One byte lane of the RAM: write port, read port with a registered read byte.
// The read register captures the array at read acceptance; when the same word
// is written in that cycle the new byte is forwarded instead of the stale one.
// Ports: CLK, RES (sync, active-high), we/waddr/wdata write port,
//        re/raddr read-capture port, rdata held read byte.
module ram_byte_bank #(
  parameter int unsigned AW = 14
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam int unsigned Depth = 2 ** AW;

  logic [7:0] mem [Depth];
  logic [7:0] rd_q;

  // Array contents survive reset on purpose.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      rd_q <= 8'h00;
    end else if (re) begin
      rd_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/ram_ahb_err.sv
// AHB-Lite RAM slave with programmable wait states, address/size/alignment
// error checking and a write-protected low region.
// Ports: CLK, RES (sync, active-high); S_H* AHB-Lite slave interface
//        (S_HMASTLOCK, S_HBURST, S_HPROT ignored); WP_EN write-protect enable;
//        S_HREADYOUT, S_HRDATA, S_HRESP slave responses.
module ram_ahb_err
  import ram_ahb_pkg::*;
#(
  parameter int unsigned RAM_SIZE    = 65536,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned WP_SIZE     = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        S_HSEL,
  input  logic [1:0]  S_HTRANS,
  input  logic        S_HWRITE,
  input  logic        S_HMASTLOCK,
  input  logic [2:0]  S_HBURST,
  input  logic [3:0]  S_HPROT,
  input  logic [2:0]  S_HSIZE,
  input  logic [31:0] S_HADDR,
  input  logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  input  logic        WP_EN,
  output logic        S_HREADYOUT,
  output logic [31:0] S_HRDATA,
  output logic        S_HRESP
);

  localparam int unsigned AW = $clog2(RAM_SIZE) - 2;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dp_q, dp_d;       // an OK data phase is in progress
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;

  logic          acc, addr_err, wp_err, final_ok, commit, re;
  logic [31:0]   rd_word;

  logic unused_ok;
  assign unused_ok = ^{S_HTRANS[0], S_HMASTLOCK, S_HBURST, S_HPROT};

  assign acc = S_HSEL & S_HREADY & S_HTRANS[1];

  // addr < WP_SIZE rewritten on word indices so it never degenerates to "x < 0".
  assign wp_err = S_HWRITE && WP_EN &&
                  (({1'b0, S_HADDR[31:2]} + 31'd1) <= 31'(WP_SIZE / 4));

  assign addr_err = (S_HADDR >= 32'(RAM_SIZE)) ||
                    (S_HSIZE > HSIZE_WORD) ||
                    ((S_HSIZE == HSIZE_HALF) && S_HADDR[0]) ||
                    ((S_HSIZE == HSIZE_WORD) && (S_HADDR[1:0] != 2'b00)) ||
                    wp_err;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_d        = dp_q;
    write_d     = write_q;
    addr_d      = addr_q;
    be_d        = be_q;
    S_HREADYOUT = 1'b1;
    S_HRESP     = RESP_OKAY;

    unique case (state_q)
      StIdle: ;
      StWait: S_HREADYOUT = (cnt_q == 4'd0);
      StErr1: begin
        S_HREADYOUT = 1'b0;
        S_HRESP     = RESP_ERROR;
      end
      StErr2: S_HRESP = RESP_ERROR;
    endcase

    if (acc) begin
      write_d = S_HWRITE;
      addr_d  = S_HADDR[AW+1:2];
      be_d    = lane_mask(S_HSIZE, S_HADDR[1:0]);
      cnt_d   = 4'(WAIT_CYCLES);
      if (addr_err) begin
        state_d = StErr1;
        dp_d    = 1'b0;
      end else begin
        state_d = (WAIT_CYCLES > 0) ? StWait : StIdle;
        dp_d    = 1'b1;
      end
    end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == StErr1) begin
      state_d = StErr2;
    end else begin
      state_d = StIdle;
      dp_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      dp_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  // dp_q is only ever set for OK transfers, so ready here means the final cycle.
  assign final_ok = dp_q && S_HREADYOUT;
  assign commit   = final_ok && write_q && !RES;
  assign re       = acc && !addr_err && !S_HWRITE;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    ram_byte_bank #(
      .AW(AW)
    ) u_bank (
      .CLK  (CLK),
      .RES  (RES),
      .we   (commit && be_q[g]),
      .waddr(addr_q),
      .wdata(S_HWDATA[8*g +: 8]),
      .re   (re),
      .raddr(S_HADDR[AW+1:2]),
      .rdata(rd_word[8*g +: 8])
    );
  end

  assign S_HRDATA = (final_ok && !write_q) ? rd_word : 32'h0;

endmodule

// File: tb/tb_ram_ahb_err.sv
// Scoreboard bench: the driver pushes the expected response of each transfer
// when it issues the address phase; a monitor tracks data phases on the bus and
// checks response, read data and wait-state count when HREADYOUT completes one.
module tb_ram_ahb_err;

  localparam int unsigned WAITS = 2;

  logic        CLK, RES;
  logic        S_HSEL, S_HWRITE, S_HMASTLOCK, WP_EN;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HBURST, S_HSIZE;
  logic [3:0]  S_HPROT;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic        S_HREADY, S_HREADYOUT, S_HRESP;

  assign S_HREADY = S_HREADYOUT;

  ram_ahb_err #(
    .RAM_SIZE   (1024),
    .WAIT_CYCLES(WAITS),
    .WP_SIZE    (256)
  ) dut (
    .CLK        (CLK),
    .RES        (RES),
    .S_HSEL     (S_HSEL),
    .S_HTRANS   (S_HTRANS),
    .S_HWRITE   (S_HWRITE),
    .S_HMASTLOCK(S_HMASTLOCK),
    .S_HBURST   (S_HBURST),
    .S_HPROT    (S_HPROT),
    .S_HSIZE    (S_HSIZE),
    .S_HADDR    (S_HADDR),
    .S_HWDATA   (S_HWDATA),
    .S_HREADY   (S_HREADY),
    .WP_EN      (WP_EN),
    .S_HREADYOUT(S_HREADYOUT),
    .S_HRDATA   (S_HRDATA),
    .S_HRESP    (S_HRESP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        resp;
    logic [31:0] rdata;
    int unsigned waits;
  } exp_t;

  exp_t exp_q[$];
  int   n_tot = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one address phase and hold it until the slave accepts it.
  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic wp);
    logic rdy;
    int   n;
    S_HSEL   = 1'b1;
    S_HTRANS = 2'b10;
    S_HWRITE = wr;
    S_HSIZE  = sz;
    S_HADDR  = a;
    WP_EN    = wp;
    n = 0;
    do begin
      @(negedge CLK);
      rdy = S_HREADYOUT;
      @(posedge CLK);
      n++;
    end while (!rdy && n < 64);
    if (!rdy) check("accept timeout", 32'd0, 32'd1);
    #1;
    S_HWDATA = wd;
    S_HSEL   = 1'b0;
    S_HTRANS = 2'b00;
    WP_EN    = 1'b0;
  endtask

  task automatic xfer(input string nm, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic wp,
                      input logic er, input logic [31:0] rd);
    exp_t e;
    e.name  = nm;
    e.resp  = er;
    e.rdata = er ? 32'h0 : rd;
    e.waits = er ? 1 : WAITS;
    exp_q.push_back(e);
    addr_phase(wr, sz, a, wd, wp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor
  bit          in_dp = 1'b0;
  int unsigned waits;
  logic        wresp, wrd;
  exp_t        e_mon;

  always @(negedge CLK) begin
    if (RES) begin
      in_dp = 1'b0;
    end else begin
      if (in_dp) begin
        if (!S_HREADYOUT) begin
          waits++;
          wresp |= S_HRESP;
          wrd   |= |S_HRDATA;
        end else begin
          if (exp_q.size() == 0) begin
            check("unexpected data phase", 32'd1, 32'd0);
          end else begin
            e_mon = exp_q.pop_front();
            check({e_mon.name, " resp"}, 32'(S_HRESP), 32'(e_mon.resp));
            check({e_mon.name, " rdata"}, S_HRDATA, e_mon.rdata);
            check({e_mon.name, " waits"}, waits, e_mon.waits);
            check({e_mon.name, " wait resp"}, 32'(wresp), 32'(e_mon.resp));
            check({e_mon.name, " wait rdata"}, 32'(wrd), 32'd0);
          end
          in_dp = 1'b0;
        end
      end
      if (S_HSEL && S_HREADY && S_HTRANS[1]) begin
        in_dp = 1'b1;
        waits = 0;
        wresp = 1'b0;
        wrd   = 1'b0;
      end
    end
  end

  initial begin
    RES = 1'b1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWRITE = 1'b0; S_HMASTLOCK = 1'b0;
    S_HBURST = 3'd0; S_HPROT = 4'd0; S_HSIZE = 3'd2; S_HADDR = 32'h0;
    S_HWDATA = 32'h0; WP_EN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset hreadyout", 32'(S_HREADYOUT), 32'd1);
    check("reset hresp", 32'(S_HRESP), 32'd0);
    check("reset hrdata", S_HRDATA, 32'h0);
    @(posedge CLK);
    #1 RES = 1'b0;

    // Word write/read with wait states; 0x100 is just past the protected region.
    xfer("wr 100", 1, 3'd2, 32'h100, 32'h12345678, 1, 0, 32'h0);
    idle(4);
    xfer("rd 100", 0, 3'd2, 32'h100, 32'h0, 0, 0, 32'h12345678);
    idle(4);

    // Byte write then back-to-back word read of the same word (forwarded lane 3).
    xfer("wr 200", 1, 3'd2, 32'h200, 32'h11223344, 0, 0, 32'h0);
    idle(4);
    xfer("wrb 203", 1, 3'd0, 32'h203, 32'hAB000000, 0, 0, 32'h0);
    xfer("rd fwd 200", 0, 3'd2, 32'h200, 32'h0, 0, 0, 32'hAB223344);
    idle(4);
    xfer("rd arr 200", 0, 3'd2, 32'h200, 32'h0, 0, 0, 32'hAB223344);
    idle(4);
    xfer("wrh 202", 1, 3'd1, 32'h202, 32'hBEEF0000, 0, 0, 32'h0);
    idle(4);
    xfer("rd half 200", 0, 3'd2, 32'h200, 32'h0, 0, 0, 32'hBEEF3344);
    idle(4);

    // Error cases, issued back to back; the final read follows an ERR2 directly.
    xfer("rd misalign 102", 0, 3'd2, 32'h102, 32'h0, 0, 1, 32'h0);
    xfer("rd range 400", 0, 3'd2, 32'h400, 32'h0, 0, 1, 32'h0);
    xfer("wrh misalign 201", 1, 3'd1, 32'h201, 32'hFFFFFFFF, 0, 1, 32'h0);
    xfer("rd size3 200", 0, 3'd3, 32'h200, 32'h0, 0, 1, 32'h0);
    xfer("rd after err 200", 0, 3'd2, 32'h200, 32'h0, 0, 0, 32'hBEEF3344);
    idle(4);

    // Write protection.
    xfer("wr 80 unprot", 1, 3'd2, 32'h80, 32'h55AA55AA, 0, 0, 32'h0);
    idle(4);
    xfer("wr 80 prot", 1, 3'd2, 32'h80, 32'hDEADBEEF, 1, 1, 32'h0);
    xfer("wr fc prot", 1, 3'd2, 32'hFC, 32'hDEADBEEF, 1, 1, 32'h0);
    xfer("rd 80", 0, 3'd2, 32'h80, 32'h0, 0, 0, 32'h55AA55AA);
    idle(4);

    // Last word of the array.
    xfer("wr 3fc", 1, 3'd2, 32'h3FC, 32'hCAFEF00D, 1, 0, 32'h0);
    idle(4);
    xfer("rd 3fc", 0, 3'd2, 32'h3FC, 32'h0, 0, 0, 32'hCAFEF00D);
    idle(4);

    // Reset during the wait states of a write must abort it.
    xfer("wr 10", 1, 3'd2, 32'h10, 32'h13579BDF, 0, 0, 32'h0);
    idle(4);
    addr_phase(1, 3'd2, 32'h10, 32'h0BADF00D, 0);
    RES = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("abort hreadyout", 32'(S_HREADYOUT), 32'd1);
    check("abort hresp", 32'(S_HRESP), 32'd0);
    @(posedge CLK);
    #1 RES = 1'b0;
    xfer("rd 10 after abort", 0, 3'd2, 32'h10, 32'h0, 0, 0, 32'h13579BDF);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
    idle(2);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_ahb_err.md
RAM_AHB_ERR -- requirements
Module: ram_ahb_err

Interface
REQ-001 Parameter RAM_SIZE, default 65536: memory size in bytes; power of two, 1024..1048576.
REQ-002 Parameter WAIT_CYCLES, default 0: wait states inserted per data phase, range 0..15.
REQ-003 Parameter WP_SIZE, default 0: bytes from offset 0 that are write-protected while WP_EN=1; multiple of 4, at most RAM_SIZE.
REQ-004 CLK  input  1  system clock; the only clock.
REQ-005 RES  input  1  reset; synchronous and active-high.
REQ-006 S_HSEL  input  1  slave select.
REQ-007 S_HTRANS  input  2  transfer type; bit 1 set means NONSEQ or SEQ.
REQ-008 S_HWRITE  input  1  1 = write.
REQ-009 S_HMASTLOCK, S_HBURST[2:0], S_HPROT[3:0]  input  accepted and ignored.
REQ-010 S_HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
REQ-011 S_HADDR  input  32  byte address; offset = S_HADDR modulo 2^32.
REQ-012 S_HWDATA  input  32  write data, little-endian lanes.
REQ-013 S_HREADY  input  1  bus ready.
REQ-014 WP_EN  input  1  write-protect enable, sampled in the address phase.
REQ-015 S_HREADYOUT  output  1  slave ready.
REQ-016 S_HRDATA  output  32  read data.
REQ-017 S_HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-018 Accept an address phase when S_HSEL & S_HREADY & S_HTRANS[1]; otherwise no transfer starts.
REQ-019 Flag an error at address phase for any of:
- S_HADDR >= RAM_SIZE;
- S_HSIZE > 2;
- halfword with S_HADDR[0] = 1;
- word with S_HADDR[1:0] != 0;
- write with WP_EN = 1 and S_HADDR < WP_SIZE.
REQ-020 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-021 From IDLE, an accepted OK transfer goes to WAIT if WAIT_CYCLES > 0; otherwise it stays in data phase and completes next cycle.
REQ-022 In WAIT, S_HREADYOUT = 0 for exactly WAIT_CYCLES cycles, then 1 with S_HRESP = 0.
REQ-023 An accepted errored transfer goes to ERR1, then ERR2, then IDLE (or accepts a new address phase).
- ERR1: S_HREADYOUT = 0, S_HRESP = 1.
- ERR2: S_HREADYOUT = 1, S_HRESP = 1.
REQ-024 An errored write shall not modify memory; an errored read shall drive S_HRDATA = 0.
REQ-025 Writes commit in the final data-phase cycle (S_HREADYOUT = 1).
- Byte lanes enabled per HSIZE and address: byte = 1 lane, halfword = lanes {1:0} or {3:2}, word = all 4.
REQ-026 Reads sample the array at address-phase acceptance; data is held until the data phase completes.
REQ-027 S_HRDATA shall equal the read data only in the final cycle of an OK read data phase; 0 otherwise.
REQ-028 Forwarding: if a read address phase is accepted in the same cycle a write to the same word commits, each written lane returns the new write data and unwritten lanes return array data.
REQ-029 Back-to-back transfers with no idle cycle shall sustain one transfer per (WAIT_CYCLES + 1) cycles.
REQ-030 S_HREADYOUT = 1 and S_HRESP = 0 whenever not in a data phase.

Reset
REQ-031 On RES = 1 at a CLK edge:
- FSM goes to IDLE;
- wait counter, data-phase registers and forwarding flags clear;
- S_HREADYOUT = 1, S_HRESP = 0, S_HRDATA = 0.
REQ-032 Reset mid-transfer shall abort it; a pending write shall not commit; array contents are not cleared.

Structure
REQ-033 Shared package ram_ahb_pkg shall hold the HTRANS and HSIZE encodings, the FSM state type, and the RESP_OKAY/RESP_ERROR constants.
REQ-034 Sub-module ram_byte_bank: one byte-wide dual-port array with the per-lane forwarding register, instantiated four times.

Verification
REQ-035 WAIT_CYCLES = 2: write word 0x12345678 to 0x100, then read 0x100 -> 2 wait cycles each; read returns 0x12345678 with OKAY.
REQ-036 Byte write 0xAB to 0x203 followed back-to-back by a word read of 0x200 (old value 0x11223344), WAIT_CYCLES = 0 -> read returns 0xAB223344.
REQ-037 Word read at 0x102 -> ERR1 (HREADYOUT = 0, HRESP = 1), then ERR2 (HREADYOUT = 1, HRESP = 1); HRDATA = 0.
REQ-038 WP_SIZE = 256, WP_EN = 1, write 0xDEADBEEF to 0x80 -> two-cycle ERROR; a subsequent read of 0x80 returns the original value.
REQ-039 RAM_SIZE = 1024, read 0x400 -> ERROR; RES asserted during WAIT of a write to 0x10 -> next cycle HREADYOUT = 1 and 0x10 unchanged.
